gpio_pin_ctrl: RTL and testbench
================================

GPIO_PIN_CTRL -- requirements
Module: gpio_pin_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: number of GPIO pins, legal range 1..32.
REQ-002 SHALL have port pclk, input, 1: sole clock; all logic on rising edge.
REQ-003 SHALL have port p_reset, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port psel, input, 1: APB select.
REQ-005 SHALL have port penable, input, 1: APB access phase.
REQ-006 SHALL have port pwrite, input, 1: 1 = write, 0 = read.
REQ-007 SHALL have port paddr, input, 8: byte address; bits [1:0] ignored.
REQ-008 SHALL have port pwdata, input, 32: write data.
REQ-009 SHALL have port prdata, output, 32: read data.
REQ-010 SHALL have port pready, output, 1: tied 1 (zero wait states).
REQ-011 SHALL have port pslverr, output, 1: error response for an unmapped address.
REQ-012 SHALL have port n_gpio_pin_oe, output, DATA_WIDTH: per-pin output enable, active-low.
REQ-013 SHALL have port gpio_pin_out, output, DATA_WIDTH: pin drive value.
REQ-014 SHALL have port gpio_pin_in, input, DATA_WIDTH: asynchronous pin sample.
REQ-015 SHALL have port irq, output, 1: level interrupt, active-high.

Function
REQ-016 SHALL map these registers:
- 0x00 DOUT, RW
- 0x04 OE, RW, 1 = drive
- 0x08 DIN, RO
- 0x0C IEN, RW
- 0x10 IPOL, RW, 1 = rising, 0 = falling
- 0x14 ISTAT, RW1C
REQ-017 SHALL perform a write on the cycle psel=1, penable=1, pwrite=1; the register updates at that clock edge.
REQ-018 SHALL accept only pwdata[DATA_WIDTH-1:0] on writes; bits 31:DATA_WIDTH are ignored and read back as 0.
REQ-019 SHALL capture prdata at the setup edge (psel=1, penable=0, pwrite=0) and hold it through the access phase.
REQ-020 SHALL drive prdata to 0 when it is not capturing a read.
REQ-021 SHALL assert pslverr only during an access phase (psel=1, penable=1) whose address is outside 0x00-0x14.
REQ-022 SHALL have no register effect for an unmapped write, and SHALL return 0 for an unmapped read.
REQ-023 SHALL assert pslverr for a write to DIN, and that write SHALL have no effect.
REQ-024 SHALL drive gpio_pin_out = DOUT and n_gpio_pin_oe = ~OE directly from registers, so pins update 1 cycle after the write edge.
REQ-025 SHALL pass gpio_pin_in through a 2-flop synchronizer (sync1, sync2) and then a third flop (prev).
REQ-026 SHALL make DIN equal sync2, giving 2-cycle pin-to-DIN latency.
REQ-027 SHALL detect an edge on pin i when sync2[i] != prev[i] and the edge direction matches IPOL[i].
REQ-028 SHALL set ISTAT[i] on the edge following detection, regardless of IEN[i].
REQ-029 SHALL clear ISTAT[i] when software writes 1 to that bit; writing 0 SHALL leave it unchanged.
REQ-030 SHALL let set win when a W1C clear and a new edge hit the same bit in the same cycle (ISTAT[i] stays 1).
REQ-031 SHALL register irq as |(ISTAT & IEN), giving a 1-cycle lag after ISTAT/IEN changes.
REQ-032 SHALL not raise irq retroactively when IEN is set for a bit whose ISTAT is already 0.
REQ-033 SHALL raise irq (after the 1-cycle lag) when IEN is set for a bit whose ISTAT is already 1.
REQ-034 SHALL not clear any pending status when IPOL changes.
REQ-035 SHALL compare only the new IPOL against subsequent edges after an IPOL change.
REQ-036 SHALL, when DOUT is written while OE=0, store the value and drive it on gpio_pin_out, but the pin SHALL stay undriven (n_gpio_pin_oe=1).

Reset
REQ-037 SHALL, on p_reset=1 at a clock edge, clear DOUT, OE, IEN, IPOL, ISTAT, sync1, sync2, prev, prdata and irq to 0, and clear pslverr to 0.
REQ-038 SHALL, while in reset, drive n_gpio_pin_oe to all-1s (all pins tri-stated) and gpio_pin_out to 0.
REQ-039 SHALL abandon an APB transfer in progress when reset asserts; the write SHALL not take effect and there SHALL be no pslverr.
REQ-040 SHALL, on the first cycle after reset releases, not detect edges from the synchronizer pipeline refilling, because prev and sync2 start equal at 0.
REQ-041 SHALL record a pin held high at reset release as a rising edge once it reaches sync2.

Verification
REQ-042 Write 0xA5 to DOUT, then 0x0F to OE -> gpio_pin_out=0xA5 and n_gpio_pin_oe=0xF0 one cycle after the OE write edge.
REQ-043 Drive gpio_pin_in=0x3C -> DIN reads 0x3C when sampled 2+ cycles later; a read at 0x08 with pwdata ignored returns prdata=0x0000003C.
REQ-044 With IPOL=0x01 and IEN=0x01, toggle pin0 0->1 -> ISTAT[0]=1 on cycle 3 and irq=1 on cycle 4; a W1C of 0x01 -> irq=0 one cycle later.
REQ-045 With IPOL[1]=0, drive a falling edge on pin1 in the same cycle a W1C of 0x02 lands -> ISTAT[1] stays 1.
REQ-046 Read of 0x18 and write to 0x08 -> pslverr=1 in the access phase, prdata=0, no register change.
REQ-047 Assert p_reset mid-write to OE=0xFF -> after reset OE=0 and n_gpio_pin_oe=0xFF.

Source files
------------

// File: rtl/gpio_pin_ctrl.sv
// APB-controlled GPIO block: output/enable registers, synchronised input sampling,
// per-pin edge-detect interrupts with W1C status and a registered level interrupt.
module gpio_pin_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  pclk,
    input  logic                  p_reset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [7:0]            paddr,
    input  logic [31:0]           pwdata,
    output logic [31:0]           prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [DATA_WIDTH-1:0] n_gpio_pin_oe,
    output logic [DATA_WIDTH-1:0] gpio_pin_out,
    input  logic [DATA_WIDTH-1:0] gpio_pin_in,
    output logic                  irq
);

    localparam logic [5:0] ADDR_DOUT  = 6'd0;
    localparam logic [5:0] ADDR_OE    = 6'd1;
    localparam logic [5:0] ADDR_DIN   = 6'd2;
    localparam logic [5:0] ADDR_IEN   = 6'd3;
    localparam logic [5:0] ADDR_IPOL  = 6'd4;
    localparam logic [5:0] ADDR_ISTAT = 6'd5;

    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [DATA_WIDTH-1:0] oe_q, oe_d;
    logic [DATA_WIDTH-1:0] ien_q, ien_d;
    logic [DATA_WIDTH-1:0] ipol_q, ipol_d;
    logic [DATA_WIDTH-1:0] istat_q, istat_d;
    logic [DATA_WIDTH-1:0] sync1_q, sync2_q, prev_q;
    logic [31:0]           prdata_q, prdata_d;
    logic                  irq_q, irq_d;

    logic [5:0]            wordAddr;
    logic                  isMapped;
    logic                  accessPhase;
    logic                  setupRead;
    logic                  accessRead;
    logic                  regWrite;
    logic [DATA_WIDTH-1:0] wrData;
    logic [DATA_WIDTH-1:0] w1cMask;
    logic [DATA_WIDTH-1:0] edgeHit;
    logic [31:0]           rdValue;
    logic                  unusedBits;

    assign wordAddr    = paddr[7:2];
    assign isMapped    = (wordAddr <= ADDR_ISTAT);
    assign accessPhase = psel & penable;
    assign setupRead   = psel & ~penable & ~pwrite;
    assign accessRead  = accessPhase & ~pwrite;
    assign regWrite    = accessPhase & pwrite & isMapped & (wordAddr != ADDR_DIN);
    assign wrData      = pwdata[DATA_WIDTH-1:0];
    assign unusedBits  = ^{paddr[1:0], pwdata};

    assign pready  = 1'b1;
    assign pslverr = accessPhase & ~p_reset & (~isMapped | (pwrite & (wordAddr == ADDR_DIN)));

    // Pins are forced tri-stated during reset rather than waiting for the reset edge.
    assign n_gpio_pin_oe = p_reset ? '1 : ~oe_q;
    assign gpio_pin_out  = p_reset ? '0 : dout_q;
    assign prdata        = prdata_q;
    assign irq           = irq_q;

    // A pin edge counts only when its new synchronised level equals the selected polarity.
    assign edgeHit = (sync2_q ^ prev_q) & ~(sync2_q ^ ipol_q);

    always_comb begin
        rdValue = '0;
        case (wordAddr)
            ADDR_DOUT:  rdValue[DATA_WIDTH-1:0] = dout_q;
            ADDR_OE:    rdValue[DATA_WIDTH-1:0] = oe_q;
            ADDR_DIN:   rdValue[DATA_WIDTH-1:0] = sync2_q;
            ADDR_IEN:   rdValue[DATA_WIDTH-1:0] = ien_q;
            ADDR_IPOL:  rdValue[DATA_WIDTH-1:0] = ipol_q;
            ADDR_ISTAT: rdValue[DATA_WIDTH-1:0] = istat_q;
            default:    rdValue = '0;
        endcase
    end

    always_comb begin
        dout_d   = dout_q;
        oe_d     = oe_q;
        ien_d    = ien_q;
        ipol_d   = ipol_q;
        w1cMask  = '0;
        prdata_d = '0;
        irq_d    = |(istat_q & ien_q);

        if (regWrite) begin
            case (wordAddr)
                ADDR_DOUT:  dout_d  = wrData;
                ADDR_OE:    oe_d    = wrData;
                ADDR_IEN:   ien_d   = wrData;
                ADDR_IPOL:  ipol_d  = wrData;
                ADDR_ISTAT: w1cMask = wrData;
                default:    w1cMask = '0;
            endcase
        end

        // A fresh edge in the same cycle as a clear keeps the status bit set.
        istat_d = (istat_q & ~w1cMask) | edgeHit;

        if (setupRead) begin
            prdata_d = rdValue;
        end else if (accessRead) begin
            prdata_d = prdata_q;
        end
    end

    always_ff @(posedge pclk) begin
        if (p_reset) begin
            dout_q   <= '0;
            oe_q     <= '0;
            ien_q    <= '0;
            ipol_q   <= '0;
            istat_q  <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            prdata_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            dout_q   <= dout_d;
            oe_q     <= oe_d;
            ien_q    <= ien_d;
            ipol_q   <= ipol_d;
            istat_q  <= istat_d;
            sync1_q  <= gpio_pin_in;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            prdata_q <= prdata_d;
            irq_q    <= irq_d;
        end
    end

endmodule

// File: tb/tb_gpio_pin_ctrl.sv
// Directed bench for gpio_pin_ctrl: a sample-history model of the block is checked
// against the DUT every cycle, alongside hand-computed expectations per scenario.
module tb_gpio_pin_ctrl;

    localparam int DW = 8;

    logic          pclk = 1'b0;
    logic          p_reset;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [7:0]    paddr;
    logic [31:0]   pwdata;
    logic [31:0]   prdata;
    logic          pready;
    logic          pslverr;
    logic [DW-1:0] n_gpio_pin_oe;
    logic [DW-1:0] gpio_pin_out;
    logic [DW-1:0] gpio_pin_in;
    logic          irq;

    int checks = 0;
    int errors = 0;
    logic cmpEnable = 1'b0;

    gpio_pin_ctrl #(.DATA_WIDTH(DW)) dut (
        .pclk          (pclk),
        .p_reset       (p_reset),
        .psel          (psel),
        .penable       (penable),
        .pwrite        (pwrite),
        .paddr         (paddr),
        .pwdata        (pwdata),
        .prdata        (prdata),
        .pready        (pready),
        .pslverr       (pslverr),
        .n_gpio_pin_oe (n_gpio_pin_oe),
        .gpio_pin_out  (gpio_pin_out),
        .gpio_pin_in   (gpio_pin_in),
        .irq           (irq)
    );

    always #5 pclk = ~pclk;

    // Model state: register file plus the pin values seen at recent clock edges
    // (element 0 newest); DIN is the value seen two edges back.
    logic [DW-1:0] mDout, mOe, mIen, mIpol, mIstat;
    logic [DW-1:0] pinSeen[$];
    logic [31:0]   mPrdata;
    logic          mIrq;
    logic [DW-1:0] mHits, mClr;
    logic [31:0]   mNextPr;
    logic          mNextIrq;

    function automatic logic [31:0] modelRead(input logic [7:0] addr);
        logic [31:0] v;
        v = 32'h0;
        case (addr & 8'hFC)
            8'h00: v = {24'h0, mDout};
            8'h04: v = {24'h0, mOe};
            8'h08: v = {24'h0, pinSeen[1]};
            8'h0C: v = {24'h0, mIen};
            8'h10: v = {24'h0, mIpol};
            8'h14: v = {24'h0, mIstat};
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    always @(posedge pclk) begin
        if (p_reset) begin
            mDout = '0; mOe = '0; mIen = '0; mIpol = '0; mIstat = '0;
            mPrdata = 32'h0;
            mIrq = 1'b0;
            pinSeen = '{8'h00, 8'h00, 8'h00};
        end else begin
            mHits = '0;
            for (int i = 0; i < DW; i++) begin
                if (pinSeen[1][i] != pinSeen[2][i] && pinSeen[1][i] == mIpol[i])
                    mHits[i] = 1'b1;
            end
            mNextIrq = |(mIstat & mIen);
            mNextPr = 32'h0;
            if (psel && !penable && !pwrite)
                mNextPr = modelRead(paddr);
            else if (psel && penable && !pwrite)
                mNextPr = mPrdata;
            mClr = '0;
            if (psel && penable && pwrite) begin
                case (paddr & 8'hFC)
                    8'h00: mDout = pwdata[DW-1:0];
                    8'h04: mOe   = pwdata[DW-1:0];
                    8'h0C: mIen  = pwdata[DW-1:0];
                    8'h10: mIpol = pwdata[DW-1:0];
                    8'h14: mClr  = pwdata[DW-1:0];
                    default: mClr = '0;
                endcase
            end
            mIstat = (mIstat & ~mClr) | mHits;
            mIrq = mNextIrq;
            mPrdata = mNextPr;
            pinSeen.push_front(gpio_pin_in);
            void'(pinSeen.pop_back());
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge pclk) begin
        logic expErr;
        logic [7:0] wa;
        if (cmpEnable) begin
            wa = paddr & 8'hFC;
            expErr = psel && penable && !p_reset && ((wa > 8'h14) || (pwrite && wa == 8'h08));
            checkOutput("cmp_pin_out", {24'h0, gpio_pin_out}, p_reset ? 32'h0 : {24'h0, mDout});
            checkOutput("cmp_n_oe", {24'h0, n_gpio_pin_oe}, p_reset ? 32'hFF : {24'h0, ~mOe});
            checkOutput("cmp_irq", {31'h0, irq}, {31'h0, mIrq});
            checkOutput("cmp_prdata", prdata, mPrdata);
            checkOutput("cmp_pslverr", {31'h0, pslverr}, {31'h0, expErr});
            checkOutput("cmp_pready", {31'h0, pready}, 32'h1);
        end
    end

    // One full APB transfer: setup edge, access edge, then bus back to idle.
    task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                                 output logic [31:0] rdata, output logic err);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        rdata = prdata;
        err = pslverr;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic err;
        pinSeen = '{8'h00, 8'h00, 8'h00};
        p_reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'h00; pwdata = 32'h0; gpio_pin_in = '0;

        @(posedge pclk); #1;
        cmpEnable = 1'b1;
        waitEdges(2);
        @(negedge pclk);
        checkOutput("reset_n_oe", {24'h0, n_gpio_pin_oe}, 32'hFF);
        checkOutput("reset_pin_out", {24'h0, gpio_pin_out}, 32'h0);
        checkOutput("reset_irq", {31'h0, irq}, 32'h0);
        checkOutput("reset_prdata", prdata, 32'h0);
        @(posedge pclk); #1;
        p_reset = 1'b0;

        // DOUT written while OE=0 drives the value but leaves the pins undriven.
        applyStimulus(1'b1, 8'h00, 32'h0000_00A5, rd, err);
        @(negedge pclk);
        checkOutput("dout_no_oe_out", {24'h0, gpio_pin_out}, 32'hA5);
        checkOutput("dout_no_oe_n_oe", {24'h0, n_gpio_pin_oe}, 32'hFF);
        applyStimulus(1'b1, 8'h04, 32'h0000_000F, rd, err);
        @(negedge pclk);
        checkOutput("oe_write_n_oe", {24'h0, n_gpio_pin_oe}, 32'hF0);
        checkOutput("oe_write_out", {24'h0, gpio_pin_out}, 32'hA5);

        applyStimulus(1'b1, 8'h00, 32'hFFFF_FF5A, rd, err);
        applyStimulus(1'b0, 8'h00, 32'h0, rd, err);
        checkOutput("dout_upper_ignored", rd, 32'h0000_005A);
        applyStimulus(1'b1, 8'h00, 32'h0000_00A5, rd, err);

        // Input path: value appears in DIN after the synchroniser.
        @(posedge pclk); #1;
        gpio_pin_in = 8'h3C;
        waitEdges(3);
        applyStimulus(1'b0, 8'h08, 32'hDEAD_BEEF, rd, err);
        checkOutput("din_read", rd, 32'h0000_003C);
        checkOutput("din_read_err", {31'h0, err}, 32'h0);

        // Rising edge on pin0 -> ISTAT on edge 3, irq on edge 4.
        applyStimulus(1'b1, 8'h10, 32'h01, rd, err);
        applyStimulus(1'b1, 8'h0C, 32'h01, rd, err);
        @(posedge pclk); #1;
        gpio_pin_in = 8'h3D;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        checkOutput("irq_before_lag", {31'h0, irq}, 32'h0);
        @(negedge pclk);
        checkOutput("irq_after_lag", {31'h0, irq}, 32'h1);
        applyStimulus(1'b0, 8'h14, 32'h0, rd, err);
        checkOutput("istat_pin0", rd, 32'h01);
        applyStimulus(1'b1, 8'h14, 32'h01, rd, err);
        @(negedge pclk);
        checkOutput("irq_hold_after_w1c", {31'h0, irq}, 32'h1);
        @(negedge pclk);
        checkOutput("irq_clear_after_w1c", {31'h0, irq}, 32'h0);

        // Falling edge on pin1 lands on the same edge as a W1C of bit1.
        @(posedge pclk); #1;
        gpio_pin_in = 8'h3F;
        waitEdges(4);
        gpio_pin_in = 8'h3D;
        waitEdges(4);
        gpio_pin_in = 8'h3F;
        waitEdges(4);
        gpio_pin_in = 8'h3D;
        applyStimulus(1'b1, 8'h14, 32'h02, rd, err);
        applyStimulus(1'b0, 8'h14, 32'h0, rd, err);
        checkOutput("istat_set_wins", rd, 32'h02);
        applyStimulus(1'b1, 8'h0C, 32'h03, rd, err);
        @(negedge pclk);
        checkOutput("irq_ien_late_lag", {31'h0, irq}, 32'h0);
        @(negedge pclk);
        checkOutput("irq_ien_late", {31'h0, irq}, 32'h1);
        applyStimulus(1'b1, 8'h14, 32'h02, rd, err);
        applyStimulus(1'b0, 8'h14, 32'h0, rd, err);
        checkOutput("istat_cleared", rd, 32'h00);

        // Unmapped and read-only accesses.
        applyStimulus(1'b0, 8'h18, 32'h0, rd, err);
        checkOutput("unmapped_read_err", {31'h0, err}, 32'h1);
        checkOutput("unmapped_read_data", rd, 32'h0);
        applyStimulus(1'b1, 8'h08, 32'hFF, rd, err);
        checkOutput("din_write_err", {31'h0, err}, 32'h1);
        applyStimulus(1'b1, 8'h20, 32'h00, rd, err);
        checkOutput("unmapped_write_err", {31'h0, err}, 32'h1);
        applyStimulus(1'b0, 8'h0B, 32'h0, rd, err);
        checkOutput("din_low_bits_ignored", rd, 32'h3D);
        applyStimulus(1'b0, 8'h00, 32'h0, rd, err);
        checkOutput("dout_unchanged", rd, 32'hA5);
        applyStimulus(1'b0, 8'h04, 32'h0, rd, err);
        checkOutput("oe_unchanged", rd, 32'h0F);

        // Reset during the access phase of a write to OE.
        @(posedge pclk); #1;
        gpio_pin_in = 8'h00;
        waitEdges(4);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04; pwdata = 32'hFF;
        @(posedge pclk); #1;
        penable = 1'b1;
        p_reset = 1'b1;
        @(negedge pclk);
        checkOutput("reset_mid_write_err", {31'h0, pslverr}, 32'h0);
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        waitEdges(1);
        p_reset = 1'b0;
        @(negedge pclk);
        checkOutput("reset_mid_write_n_oe", {24'h0, n_gpio_pin_oe}, 32'hFF);
        applyStimulus(1'b0, 8'h04, 32'h0, rd, err);
        checkOutput("reset_mid_write_oe", rd, 32'h0);

        waitEdges(2);
        cmpEnable = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
